sevseg_scan_ctrl: RTL and testbench

//  Parametrised N-digit multiplexed hex display driver for the Basys3 7-segment bank.

---
 rtl/sevseg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sevseg_scan_ctrl
// Purpose  : Multiplexed N-digit hex display driver. It holds a shadow copy of
//            the hex word and commits that copy to the active copy only at a
//            frame boundary, so the display never tears. One active-low anode
//            is enabled per slot, with a ghosting guard at the start of each
//            slot. It also handles per-digit blanking, leading-zero
//            suppression and decimal points.
// Revision : 1.0 - initial release
// ============================================================================
module sevseg_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            ca,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] c_guard    = CNT_W'(GUARD);

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [4*N_DIGITS-1:0] shadow_data_q, active_data_q;
  logic [N_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                  pending_q;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            ca_q, ca_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic [N_DIGITS-1:0]   w_zero_from;  // bit i: active digits i..N-1 are all zero
  logic [N_DIGITS-1:0]   w_vis;
  logic [3:0]            w_digit;

  assign w_slot_end = (cnt_q == c_cnt_last);
  assign w_wrap     = w_slot_end && (idx_q == c_idx_last);
  assign w_digit    = active_data_q[{idx_q, 2'b00} +: 4];

  // Segment pattern for one hex digit, {CA..CG}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Slot counter and digit index; the index wraps after the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (w_slot_end) begin
      cnt_q <= '0;
      idx_q <= (idx_q == c_idx_last) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Shadow capture on load. The shadow is committed to the active copy only at
  // the frame wrap, so a load coinciding with the wrap stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      frame_tick_q <= w_wrap;
      if (w_wrap && pending_q) begin
        active_data_q <= shadow_data_q;
        active_dp_q   <= shadow_dp_q;
      end
      if (load) begin
        shadow_data_q <= data_in;
        shadow_dp_q   <= dp_in;
        pending_q     <= 1'b1;
      end else if (w_wrap) begin
        pending_q     <= 1'b0;
      end
    end
  end

  // Digit visibility. Leading zeros are found from the top digit downwards;
  // digit 0 is never suppressed, so "0" still shows.
  always_comb begin
    logic run;
    run         = 1'b1;
    w_zero_from = '0;
    w_vis       = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run            = run & (active_data_q[4*i +: 4] == 4'h0);
      w_zero_from[i] = run;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      w_vis[i] = ~blank_in[i] & ~(lz_en & (i > 0) & w_zero_from[i]);
    end
  end

  // Next output values. All dark during the guard window or for a hidden digit.
  always_comb begin
    an_d = '1;
    ca_d = 7'h7F;
    dp_d = 1'b1;
    if ((cnt_q >= c_guard) && w_vis[idx_q]) begin
      an_d = ~(N_DIGITS'(1) << idx_q);
      ca_d = hex7(w_digit);
      dp_d = ~active_dp_q[idx_q];
    end
  end

  // Registered pin drivers, so an/ca/dp never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q <= '1;
      ca_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      an_q <= an_d;
      ca_q <= ca_d;
      dp_q <= dp_d;
    end
  end

  assign an         = an_q;
  assign ca         = ca_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevseg_scan_ctrl
// Purpose  : Bench for sevseg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle
//            guard). It compares every output on every cycle against an
//            arithmetic scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_ctrl;

  localparam int c_nd  = 4;
  localparam int c_div = 8;
  localparam int c_grd = 2;
  localparam int c_frame = c_nd * c_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        dp;
  logic        frame_tick;

  sevseg_scan_ctrl #(.N_DIGITS(c_nd), .TICK_DIV(c_div), .GUARD(c_grd)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .an(an), .ca(ca), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: elapsed cycles since reset release plus the two copies.
  int          t;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_sdp, m_adp;
  bit          m_pend;
  logic [6:0]  seg_tbl [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0; m_pend = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_ca"}, 32'(ca), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_ft"}, 32'(frame_tick), 32'h0);
  endtask

  // One clock: predict outputs from the pre-edge model state and the live
  // inputs, advance the model, then compare just after the edge.
  task automatic step();
    int cnt, idx, hi;
    bit vis;
    logic [3:0] e_an;
    logic [6:0] e_ca;
    logic       e_dp, e_ft;
    cnt = t % c_div;
    idx = (t / c_div) % c_nd;
    hi = 0;
    for (int k = 0; k < c_nd; k++) if (m_active[4*k +: 4] != 4'h0) hi = k;
    vis = (blank_in[idx] == 1'b0) && !(lz_en && idx > hi);
    e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1;
    if (cnt >= c_grd && vis) begin
      e_an = 4'hF ^ 4'(1 << idx);
      e_ca = seg_tbl[m_active[4*idx +: 4]];
      e_dp = ~m_adp[idx];
    end
    e_ft = (t % c_frame) == c_frame - 1;
    if (e_ft && m_pend) begin
      m_active = m_shadow; m_adp = m_sdp;
    end
    if (load) begin
      m_shadow = data_in; m_sdp = dp_in; m_pend = 1;
    end else if (e_ft) begin
      m_pend = 0;
    end
    t++;
    @(posedge clk); #1;
    chk("an", 32'(an), 32'(e_an));
    chk("ca", 32'(ca), 32'(e_ca));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_until_phase(input int ph);
    for (int i = 0; i < c_frame && (t % c_frame) != ph; i++) step();
  endtask

  initial begin
    seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    model_reset();

    // Reset state, held across a few edges.
    #23;
    chk_reset("rst_hold");
    @(negedge clk); rst = 1'b0;
    model_reset();
    chk_reset("rst_release");

    // Idle frame shows 0 on every digit; then a mid-frame load of 12AF.
    run(10);
    do_load(16'h12AF, 4'b0000);
    run(2 * c_frame);

    // Load exactly on the commit cycle: old value shows one more frame.
    run_until_phase(c_frame - 1);
    do_load(16'h0005, 4'b0000);
    lz_en = 1'b1;
    run(2 * c_frame + 5);
    lz_en = 1'b0;
    run(c_frame);

    // Blanking and decimal points.
    do_load(16'h3C7E, 4'b0001);
    blank_in = 4'b0100;
    run(2 * c_frame);
    blank_in = 4'b0000;

    // Back-to-back loads: last wins.
    do_load(16'hAAAA, 4'b1111);
    do_load(16'h0B90, 4'b0010);
    lz_en = 1'b1;
    run(2 * c_frame);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        blank_in = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
        lz_en    = 1'($urandom);
      end
      if ($urandom % 12 == 0) begin
        case ($urandom % 5)
          0: data_in = 16'($urandom);
          1: data_in = 16'($urandom) & 16'h0FFF;
          2: data_in = 16'($urandom) & 16'h00FF;
          3: data_in = 16'($urandom) & 16'h000F;
          default: data_in = 16'h0000;
        endcase
        dp_in = 4'($urandom);
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      step();
    end
    load = 1'b0; blank_in = 4'b0000; lz_en = 1'b0;

    // Asynchronous reset during digit 2 with a pending load.
    run_until_phase(3);
    do_load(16'h9876, 4'b1010);
    run_until_phase(2 * c_div + 3);
    chk("pending_before_rst", 32'(m_pend), 32'h1);
    rst = 1'b1;
    #2;
    model_reset();
    chk_reset("rst_async");
    @(negedge clk); rst = 1'b0;
    chk_reset("rst_async_release");
    run(2 * c_frame);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
